scoreboard_wb_arbiter: RTL and testbench
========================================

# scoreboard_wb_arbiter

Write-result stage controller for the scoreboard: arbitrates the single register-file write port among NUM_FUS functional units that have finished execution. Each cycle it grants at most one FU, chosen round-robin among requesters that are free of WAR hazards. It drives a registered write-back transaction and a one-cycle release pulse back to the granted FU. It sits between the functional units and the register file / scoreboard status tables, downstream of issue and read-operands.

## Interface
- NUM_FUS, 4, number of functional units
- NUM_REGS, 32, architectural registers
- REG_BITS, 5, register index width
- FU_BITS, 2, FU index width
- DATA_WIDTH, 32, result width
- STALL_CNT_W, 16, width of WAR-stall performance counter

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- fu_busy  in  NUM_FUS  FU status Busy bit
- fu_done_req  in  NUM_FUS  FU finished execution; held high until fu_grant seen
- fu_fi  in  NUM_FUS*REG_BITS  destination register per FU (FU f at [f*REG_BITS +: REG_BITS])
- fu_fj, fu_fk  in  NUM_FUS*REG_BITS each  source registers per FU
- fu_rj, fu_rk  in  NUM_FUS each  source operand not yet read (Rj/Rk)
- fu_result  in  NUM_FUS*DATA_WIDTH  result per FU
- wb_ready  in  1  register file can accept a write this cycle
- wb_valid  out  1  registered write strobe
- wb_reg  out  REG_BITS  destination register
- wb_data  out  DATA_WIDTH  write data
- wb_fu  out  FU_BITS  index of FU being retired
- fu_grant  out  NUM_FUS  one-hot, one-cycle release pulse (scoreboard clears FU status)
- war_stall  out  1  combinational: ≥1 request pending, none eligible due to WAR
- war_stall_cnt  out  STALL_CNT_W  saturating count of war_stall cycles

## Operation
- WAR block for FU f: exists g≠f with fu_busy[g] and ((fu_fj[g]==fu_fi[f] && fu_rj[g]) || (fu_fk[g]==fu_fi[f] && fu_rk[g])). Never blocked when fu_fi[f]==0.
- Eligible[f] = fu_done_req[f] && fu_busy[f] && !war_block[f] && !fu_grant[f] (the registered grant masks the FU retired last cycle while its request is still dropping).
- Arbitration is performed only when wb_ready=1; otherwise no grant is issued and the pointer holds.
- Round-robin pointer rr_ptr (FU_BITS): search starts at rr_ptr, ascends, and wraps modulo NUM_FUS. The first eligible FU wins. On a grant to f, rr_ptr <= (f+1) mod NUM_FUS.
- On a grant: wb_valid<=1, wb_reg<=fu_fi[f], wb_data<=fu_result[f], wb_fu<=f, fu_grant<=one-hot(f). Otherwise wb_valid<=0 and fu_grant<=0; wb_reg, wb_data and wb_fu hold their last values.
- A dest of 0 is still granted and written. The register file ignores writes to r0.
- war_stall = (|(fu_done_req & fu_busy & ~fu_grant)) && !(|eligible) && wb_ready.
- war_stall_cnt increments each cycle war_stall=1 and saturates at all-ones.
- Reset: rr_ptr=0; wb_valid=0, wb_reg=0, wb_data=0, wb_fu=0, fu_grant=0, war_stall_cnt=0.

## Timing
- Latency: request eligible in cycle N → wb_valid/fu_grant high in cycle N+1 for exactly one cycle.
- Throughput: one write-back per cycle. The same FU cannot be granted in two consecutive cycles.
- The FU must deassert fu_done_req in the cycle it sees fu_grant. The scoreboard clears Busy/Fi at the end of that cycle.
- Inputs are sampled at the edge ending cycle N. A WAR block that clears in cycle N makes the FU eligible in cycle N, with its grant in N+1.
- Simultaneous requests: exactly one grant, chosen by rr_ptr order. Others stay pending with no loss.
- wb_ready low in cycle N: no grant in N+1; the pointer and counter continue per the rules above.
- Reset asserted mid-transaction: at the next edge all outputs are forced to reset values, and any in-flight grant is dropped (wb_valid=0 next cycle).

## Test plan
- Single request: FU2 req, fi=7, result=0xDEADBEEF, no hazards → next cycle wb_valid=1, wb_reg=7, wb_data=0xDEADBEEF, wb_fu=2, fu_grant=0100; then 0000.
- Round-robin: FU0, FU1 and FU3 request together, held until granted, rr_ptr=0 → grants FU0, FU1, FU3 on consecutive cycles; rr_ptr ends at 0.
- WAR: FU1 dest r5; FU2 busy, fj=5, rj=1 → no grant, war_stall=1, counter increments; drop rj → grant FU1 the following cycle.
- r0 exemption: FU0 dest r0; FU3 busy, fj=0, rj=1 → FU0 granted next cycle, wb_reg=0.
- Back-pressure: FU1 requesting, wb_ready=0 for 3 cycles → no grant, war_stall=0; wb_ready=1 → grant one cycle later.
- Reset mid-grant: rst_n low in the cycle fu_grant=0010 → next cycle all outputs 0, war_stall_cnt=0, rr_ptr=0 (next simultaneous FU0/FU1 request grants FU0 first).

Source files
------------

// File: rtl/scoreboard_wb_arbiter.sv
// rtl/scoreboard_wb_arbiter.sv - write-result arbiter granting the register-file write port to one WAR-free FU per cycle
module scoreboard_wb_arbiter #(
    parameter int NUM_FUS     = 4,
    parameter int NUM_REGS    = 32,
    parameter int REG_BITS    = $clog2(NUM_REGS),
    parameter int FU_BITS     = $clog2(NUM_FUS),
    parameter int DATA_WIDTH  = 32,
    parameter int STALL_CNT_W = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_FUS-1:0]             fu_busy,
    input  logic [NUM_FUS-1:0]             fu_done_req,
    input  logic [NUM_FUS*REG_BITS-1:0]    fu_fi,
    input  logic [NUM_FUS*REG_BITS-1:0]    fu_fj,
    input  logic [NUM_FUS*REG_BITS-1:0]    fu_fk,
    input  logic [NUM_FUS-1:0]             fu_rj,
    input  logic [NUM_FUS-1:0]             fu_rk,
    input  logic [NUM_FUS*DATA_WIDTH-1:0]  fu_result,
    input  logic                           wb_ready,
    output logic                           wb_valid,
    output logic [REG_BITS-1:0]            wb_reg,
    output logic [DATA_WIDTH-1:0]          wb_data,
    output logic [FU_BITS-1:0]             wb_fu,
    output logic [NUM_FUS-1:0]             fu_grant,
    output logic                           war_stall,
    output logic [STALL_CNT_W-1:0]         war_stall_cnt
);

    logic [NUM_FUS-1:0]     war_block;
    logic [NUM_FUS-1:0]     eligible;
    logic [FU_BITS-1:0]     win;
    logic [FU_BITS-1:0]     idx;
    logic                   found;
    logic                   grant;

    logic                   wb_valid_q, wb_valid_d;
    logic [REG_BITS-1:0]    wb_reg_q, wb_reg_d;
    logic [DATA_WIDTH-1:0]  wb_data_q, wb_data_d;
    logic [FU_BITS-1:0]     wb_fu_q, wb_fu_d;
    logic [NUM_FUS-1:0]     grant_q, grant_d;
    logic [FU_BITS-1:0]     rr_ptr_q, rr_ptr_d;
    logic [STALL_CNT_W-1:0] cnt_q, cnt_d;

    // A pending read of our destination by another busy FU blocks the write; r0 is never blocked.
    always_comb begin
        war_block = '0;
        for (int f = 0; f < NUM_FUS; f++) begin
            for (int g = 0; g < NUM_FUS; g++) begin
                if (g != f && fu_busy[g] && fu_fi[f*REG_BITS +: REG_BITS] != '0 &&
                    ((fu_fj[g*REG_BITS +: REG_BITS] == fu_fi[f*REG_BITS +: REG_BITS] && fu_rj[g]) ||
                     (fu_fk[g*REG_BITS +: REG_BITS] == fu_fi[f*REG_BITS +: REG_BITS] && fu_rk[g]))) begin
                    war_block[f] = 1'b1;
                end
            end
        end
    end

    assign eligible = fu_done_req & fu_busy & ~war_block & ~grant_q;

    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int i = 0; i < NUM_FUS; i++) begin
            idx = FU_BITS'((int'(rr_ptr_q) + i) % NUM_FUS);
            if (!found && eligible[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign grant     = found & wb_ready;
    assign war_stall = (|(fu_done_req & fu_busy & ~grant_q)) && !(|eligible) && wb_ready;

    always_comb begin
        wb_valid_d = 1'b0;
        grant_d    = '0;
        wb_reg_d   = wb_reg_q;
        wb_data_d  = wb_data_q;
        wb_fu_d    = wb_fu_q;
        rr_ptr_d   = rr_ptr_q;
        cnt_d      = cnt_q;
        if (grant) begin
            wb_valid_d = 1'b1;
            wb_reg_d   = fu_fi[win*REG_BITS +: REG_BITS];
            wb_data_d  = fu_result[win*DATA_WIDTH +: DATA_WIDTH];
            wb_fu_d    = win;
            grant_d    = {{(NUM_FUS-1){1'b0}}, 1'b1} << win;
            rr_ptr_d   = (win == FU_BITS'(NUM_FUS - 1)) ? '0 : win + 1'b1;
        end
        if (war_stall && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_valid_q <= 1'b0;
            wb_reg_q   <= '0;
            wb_data_q  <= '0;
            wb_fu_q    <= '0;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            cnt_q      <= '0;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_reg_q   <= wb_reg_d;
            wb_data_q  <= wb_data_d;
            wb_fu_q    <= wb_fu_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            cnt_q      <= cnt_d;
        end
    end

    assign wb_valid      = wb_valid_q;
    assign wb_reg        = wb_reg_q;
    assign wb_data       = wb_data_q;
    assign wb_fu         = wb_fu_q;
    assign fu_grant      = grant_q;
    assign war_stall_cnt = cnt_q;

endmodule

// File: tb/tb_scoreboard_wb_arbiter.sv
// tb/tb_scoreboard_wb_arbiter.sv - table-driven and randomized checks of scoreboard_wb_arbiter
module tb_scoreboard_wb_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   fu_busy, fu_done_req, fu_rj, fu_rk, fu_grant;
    logic [19:0]  fu_fi, fu_fj, fu_fk;
    logic [127:0] fu_result;
    logic         wb_ready, wb_valid, war_stall;
    logic [4:0]   wb_reg;
    logic [31:0]  wb_data;
    logic [1:0]   wb_fu;
    logic [15:0]  war_stall_cnt;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    scoreboard_wb_arbiter dut (
        .clk(clk), .rst_n(rst_n), .fu_busy(fu_busy), .fu_done_req(fu_done_req),
        .fu_fi(fu_fi), .fu_fj(fu_fj), .fu_fk(fu_fk), .fu_rj(fu_rj), .fu_rk(fu_rk),
        .fu_result(fu_result), .wb_ready(wb_ready), .wb_valid(wb_valid), .wb_reg(wb_reg),
        .wb_data(wb_data), .wb_fu(wb_fu), .fu_grant(fu_grant), .war_stall(war_stall),
        .war_stall_cnt(war_stall_cnt)
    );

    typedef struct {
        logic        rst;
        logic        rdy;
        logic [3:0]  busy, req, rj, rk;
        logic [19:0] fi, fj, fk;
        logic        stall, valid;
        logic [4:0]  wreg;
        logic [1:0]  wfu;
        logic [3:0]  grant;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[$];
    logic [31:0] res[4] = '{32'hA5A5A5A5, 32'h11111111, 32'hDEADBEEF, 32'h33333333};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [19:0] r4(input int a3, input int a2, input int a1, input int a0);
        return {5'(a3), 5'(a2), 5'(a1), 5'(a0)};
    endfunction

    function automatic vec_t mk(input logic rst, input logic rdy, input logic [3:0] busy,
                                input logic [3:0] req, input logic [3:0] rj, input logic [3:0] rk,
                                input logic [19:0] fi, input logic [19:0] fj, input logic [19:0] fk,
                                input logic stall, input logic valid, input logic [4:0] wreg,
                                input logic [1:0] wfu, input logic [3:0] grant, input logic [15:0] cnt);
        vec_t t;
        t.rst = rst; t.rdy = rdy; t.busy = busy; t.req = req; t.rj = rj; t.rk = rk;
        t.fi = fi; t.fj = fj; t.fk = fk; t.stall = stall; t.valid = valid;
        t.wreg = wreg; t.wfu = wfu; t.grant = grant; t.cnt = cnt;
        return t;
    endfunction

    task automatic run_row(input vec_t t, input int n);
        logic [31:0] ed;
        @(negedge clk);
        rst_n = t.rst; wb_ready = t.rdy; fu_busy = t.busy; fu_done_req = t.req;
        fu_rj = t.rj; fu_rk = t.rk; fu_fi = t.fi; fu_fj = t.fj; fu_fk = t.fk;
        #1;
        check($sformatf("row%0d war_stall", n), 32'(war_stall), 32'(t.stall));
        @(posedge clk);
        #1;
        check($sformatf("row%0d wb_valid", n), 32'(wb_valid), 32'(t.valid));
        check($sformatf("row%0d wb_reg", n), 32'(wb_reg), 32'(t.wreg));
        check($sformatf("row%0d wb_fu", n), 32'(wb_fu), 32'(t.wfu));
        check($sformatf("row%0d fu_grant", n), 32'(fu_grant), 32'(t.grant));
        check($sformatf("row%0d war_stall_cnt", n), 32'(war_stall_cnt), 32'(t.cnt));
        if (!t.rst || t.valid) begin
            ed = t.rst ? res[t.wfu] : 32'h0;
            check($sformatf("row%0d wb_data", n), wb_data, ed);
        end
    endtask

    // model state for the randomized phase
    int          m_ptr, m_prev, m_cnt, m_fu;
    logic        m_valid;
    logic [4:0]  m_reg;
    logic [31:0] m_data;

    initial begin
        rst_n = 1'b0; wb_ready = 1'b1; fu_busy = '0; fu_done_req = '0; fu_rj = '0; fu_rk = '0;
        fu_fi = '0; fu_fj = '0; fu_fk = '0;
        fu_result = {res[3], res[2], res[1], res[0]};

        // rst rdy busy req rj rk fi fj fk | stall valid reg fu grant cnt
        tbl.push_back(mk(0, 1, 4'b0000, 4'b0000, 0, 0, r4(0,0,0,0), 0, 0, 0, 0, 5'd0, 2'd0, 4'b0000, 16'd0));
        tbl.push_back(mk(1, 1, 4'b0100, 4'b0100, 0, 0, r4(0,7,0,0), 0, 0, 0, 1, 5'd7, 2'd2, 4'b0100, 16'd0));
        tbl.push_back(mk(1, 1, 4'b0100, 4'b0000, 0, 0, r4(0,7,0,0), 0, 0, 0, 0, 5'd7, 2'd2, 4'b0000, 16'd0));
        tbl.push_back(mk(1, 1, 4'b0000, 4'b0000, 0, 0, r4(0,0,0,0), 0, 0, 0, 0, 5'd7, 2'd2, 4'b0000, 16'd0));
        tbl.push_back(mk(0, 1, 4'b0000, 4'b0000, 0, 0, r4(0,0,0,0), 0, 0, 0, 0, 5'd0, 2'd0, 4'b0000, 16'd0));
        tbl.push_back(mk(1, 1, 4'b1011, 4'b1011, 0, 0, r4(3,0,2,1), 0, 0, 0, 1, 5'd1, 2'd0, 4'b0001, 16'd0));
        tbl.push_back(mk(1, 1, 4'b1011, 4'b1010, 0, 0, r4(3,0,2,1), 0, 0, 0, 1, 5'd2, 2'd1, 4'b0010, 16'd0));
        tbl.push_back(mk(1, 1, 4'b1010, 4'b1000, 0, 0, r4(3,0,2,1), 0, 0, 0, 1, 5'd3, 2'd3, 4'b1000, 16'd0));
        tbl.push_back(mk(1, 1, 4'b1000, 4'b0000, 0, 0, r4(3,0,2,1), 0, 0, 0, 0, 5'd3, 2'd3, 4'b0000, 16'd0));
        tbl.push_back(mk(1, 1, 4'b0011, 4'b0011, 0, 0, r4(0,0,6,4), 0, 0, 0, 1, 5'd4, 2'd0, 4'b0001, 16'd0));
        tbl.push_back(mk(1, 1, 4'b0011, 4'b0010, 0, 0, r4(0,0,6,4), 0, 0, 0, 1, 5'd6, 2'd1, 4'b0010, 16'd0));
        tbl.push_back(mk(1, 1, 4'b0010, 4'b0000, 0, 0, r4(0,0,6,4), 0, 0, 0, 0, 5'd6, 2'd1, 4'b0000, 16'd0));
        tbl.push_back(mk(1, 1, 4'b0110, 4'b0010, 4'b0100, 0, r4(0,0,5,0), r4(0,5,0,0), 0, 1, 0, 5'd6, 2'd1, 4'b0000, 16'd1));
        tbl.push_back(mk(1, 1, 4'b0110, 4'b0010, 4'b0100, 0, r4(0,0,5,0), r4(0,5,0,0), 0, 1, 0, 5'd6, 2'd1, 4'b0000, 16'd2));
        tbl.push_back(mk(1, 1, 4'b0110, 4'b0010, 4'b0000, 0, r4(0,0,5,0), r4(0,5,0,0), 0, 0, 1, 5'd5, 2'd1, 4'b0010, 16'd2));
        tbl.push_back(mk(1, 1, 4'b0100, 4'b0000, 4'b0000, 0, r4(0,0,5,0), r4(0,5,0,0), 0, 0, 0, 5'd5, 2'd1, 4'b0000, 16'd2));
        tbl.push_back(mk(1, 1, 4'b1001, 4'b0001, 4'b1000, 0, r4(0,0,0,0), r4(0,0,0,0), 0, 0, 1, 5'd0, 2'd0, 4'b0001, 16'd2));
        tbl.push_back(mk(1, 1, 4'b1001, 4'b0000, 4'b1000, 0, r4(0,0,0,0), r4(0,0,0,0), 0, 0, 0, 5'd0, 2'd0, 4'b0000, 16'd2));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1, 0, 4'b0010, 4'b0010, 0, 0, r4(0,0,9,0), 0, 0, 0, 0, 5'd0, 2'd0, 4'b0000, 16'd2));
        tbl.push_back(mk(1, 1, 4'b0010, 4'b0010, 0, 0, r4(0,0,9,0), 0, 0, 0, 1, 5'd9, 2'd1, 4'b0010, 16'd2));
        tbl.push_back(mk(1, 1, 4'b0010, 4'b0000, 0, 0, r4(0,0,9,0), 0, 0, 0, 0, 5'd9, 2'd1, 4'b0000, 16'd2));
        tbl.push_back(mk(1, 1, 4'b0010, 4'b0010, 0, 0, r4(0,0,10,0), 0, 0, 0, 1, 5'd10, 2'd1, 4'b0010, 16'd2));
        tbl.push_back(mk(0, 1, 4'b0010, 4'b0000, 0, 0, r4(0,0,10,0), 0, 0, 0, 0, 5'd0, 2'd0, 4'b0000, 16'd0));
        tbl.push_back(mk(1, 1, 4'b0011, 4'b0011, 0, 0, r4(0,0,12,11), 0, 0, 0, 1, 5'd11, 2'd0, 4'b0001, 16'd0));
        tbl.push_back(mk(1, 1, 4'b0011, 4'b0010, 0, 0, r4(0,0,12,11), 0, 0, 0, 1, 5'd12, 2'd1, 4'b0010, 16'd0));
        tbl.push_back(mk(1, 1, 4'b0010, 4'b0000, 0, 0, r4(0,0,12,11), 0, 0, 0, 0, 5'd12, 2'd1, 4'b0000, 16'd0));

        for (int i = 0; i < tbl.size(); i++) run_row(tbl[i], i);

        // WAR through fk/rk: FU3 writes r8 while busy FU0 still needs r8 as Fk; pointer is at 2 here
        @(negedge clk);
        fu_busy = 4'b1001; fu_done_req = 4'b1000; fu_fi = r4(8,0,0,0);
        fu_fj = '0; fu_fk = r4(0,0,0,8); fu_rj = '0; fu_rk = 4'b0001;
        #1 check("fk_war stall", 32'(war_stall), 32'd1);
        @(posedge clk);
        #1 check("fk_war no grant", 32'(wb_valid), 32'd0);
        check("fk_war cnt", 32'(war_stall_cnt), 32'd1);
        @(negedge clk);
        fu_rk = 4'b0000;
        #1 check("fk_clear stall", 32'(war_stall), 32'd0);
        @(posedge clk);
        #1 check("fk_clear valid", 32'(wb_valid), 32'd1);
        check("fk_clear grant", 32'(fu_grant), 32'h8);
        check("fk_clear reg", 32'(wb_reg), 32'd8);
        check("fk_clear data", wb_data, 32'h33333333);
        @(negedge clk);
        fu_done_req = 4'b0000;
        @(posedge clk);
        #1 check("fk_release grant", 32'(fu_grant), 32'd0);

        // randomized phase against a rule-level model
        for (int n = 0; n < 400; n++) begin
            bit   el[4];
            bit   pend, anyel, blk;
            int   win;
            logic stall_exp;
            @(negedge clk);
            rst_n = (n == 0) ? 1'b0 : ($urandom_range(0, 60) != 0);
            wb_ready = ($urandom_range(0, 3) != 0);
            fu_busy = 4'($urandom); fu_done_req = 4'($urandom);
            fu_rj = 4'($urandom) & 4'($urandom); fu_rk = 4'($urandom) & 4'($urandom);
            for (int f = 0; f < 4; f++) begin
                fu_fi[f*5 +: 5] = 5'($urandom_range(0, 3));
                fu_fj[f*5 +: 5] = 5'($urandom_range(0, 3));
                fu_fk[f*5 +: 5] = 5'($urandom_range(0, 3));
                fu_result[f*32 +: 32] = $urandom;
            end
            #1;
            pend = 0; anyel = 0; win = -1;
            for (int f = 0; f < 4; f++) begin
                blk = 0;
                el[f] = 0;
                if (fu_fi[f*5 +: 5] != 0)
                    for (int g = 0; g < 4; g++)
                        if (g != f && fu_busy[g] &&
                            ((fu_fj[g*5 +: 5] == fu_fi[f*5 +: 5] && fu_rj[g]) ||
                             (fu_fk[g*5 +: 5] == fu_fi[f*5 +: 5] && fu_rk[g])))
                            blk = 1;
                if (fu_done_req[f] && fu_busy[f] && f != m_prev) begin
                    pend = 1;
                    if (!blk) begin el[f] = 1; anyel = 1; end
                end
            end
            if (wb_ready)
                for (int k = 0; k < 4; k++)
                    if (win < 0 && el[(m_ptr + k) % 4]) win = (m_ptr + k) % 4;
            stall_exp = pend && !anyel && wb_ready;
            check($sformatf("rnd%0d war_stall", n), 32'(war_stall), 32'(stall_exp));
            @(posedge clk);
            #1;
            if (!rst_n) begin
                m_ptr = 0; m_prev = -1; m_cnt = 0; m_fu = 0; m_valid = 0; m_reg = 0; m_data = 0;
            end else begin
                if (stall_exp && m_cnt < 65535) m_cnt++;
                if (win >= 0) begin
                    m_valid = 1; m_fu = win; m_reg = fu_fi[win*5 +: 5];
                    m_data = fu_result[win*32 +: 32]; m_ptr = (win + 1) % 4; m_prev = win;
                end else begin
                    m_valid = 0; m_prev = -1;
                end
            end
            check($sformatf("rnd%0d wb_valid", n), 32'(wb_valid), 32'(m_valid));
            check($sformatf("rnd%0d wb_reg", n), 32'(wb_reg), 32'(m_reg));
            check($sformatf("rnd%0d wb_fu", n), 32'(wb_fu), 32'(m_fu));
            check($sformatf("rnd%0d wb_data", n), wb_data, m_data);
            check($sformatf("rnd%0d fu_grant", n), 32'(fu_grant), m_valid ? (32'd1 << m_fu) : 32'd0);
            check($sformatf("rnd%0d war_stall_cnt", n), 32'(war_stall_cnt), 32'(m_cnt));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
